replicate_concat_pipe: RTL

//  Parametrised, pipelined successor to the fixed {a, {4{b[0]}}, c[1]} packer.

---
 rtl/replicate_concat_pipe.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/replicate_concat_pipe.sv
// Two-stage valid/ready packer: y = {a, fill, c[c_sel]}, where fill replicates
// the selected b bit under a runtime count/mode. Also counts output transfers.
module replicate_concat_pipe #(
    parameter int A_W     = 1,
    parameter int B_W     = 2,
    parameter int C_W     = 4,
    parameter int REP_MAX = 4,
    parameter int CNT_W   = 16,
    localparam int Y_W    = A_W + REP_MAX + 1,
    localparam int SB_W   = (B_W > 1) ? $clog2(B_W) : 1,
    localparam int SC_W   = (C_W > 1) ? $clog2(C_W) : 1,
    localparam int R_W    = $clog2(REP_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic [SB_W-1:0]  b_sel,
    input  logic [C_W-1:0]   c,
    input  logic [SC_W-1:0]  c_sel,
    input  logic [R_W-1:0]   rep_cnt,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Y_W-1:0]   y,
    output logic             out_err,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam logic [SB_W:0]  B_LIM = (SB_W + 1)'(B_W);
    localparam logic [SC_W:0]  C_LIM = (SC_W + 1)'(C_W);
    localparam logic [R_W-1:0] R_LIM = R_W'(REP_MAX);

    // Handshake: a stage loads when it is empty or its successor is loading,
    // so in_ready is combinational from out_ready and no bubbles are inserted.
    logic w_s2_load;
    logic w_s1_load;
    logic w_s1_accept;

    // Stage-1 input decode
    logic           w_b_ok;
    logic           w_c_ok;
    logic           w_rb;
    logic           w_cb;
    logic           w_over;
    logic [R_W-1:0] w_cnt;
    logic           w_err;

    // Stage-1 registers
    logic           r_s1_valid;
    logic [A_W-1:0] r_s1_a;
    logic           r_s1_b;
    logic           r_s1_c;
    logic [R_W-1:0] r_s1_cnt;
    logic [1:0]     r_s1_mode;
    logic           r_s1_err;

    // Stage-2 assembly and registers
    logic [REP_MAX-1:0] w_fill;
    logic [Y_W-1:0]     w_y;
    logic               r_s2_valid;
    logic [Y_W-1:0]     r_y;
    logic               r_err;
    logic [CNT_W-1:0]   r_xfer;

    assign w_s2_load   = !r_s2_valid || out_ready;
    assign w_s1_load   = !r_s1_valid || w_s2_load;
    assign w_s1_accept = in_valid && w_s1_load;

    // Out-of-range selects fall back to bit 0 and raise the error flag.
    assign w_b_ok = ({1'b0, b_sel} < B_LIM);
    assign w_c_ok = ({1'b0, c_sel} < C_LIM);
    assign w_rb   = w_b_ok ? b[b_sel] : b[0];
    assign w_cb   = w_c_ok ? c[c_sel] : c[0];
    assign w_over = (rep_cnt > R_LIM);
    assign w_cnt  = w_over ? R_LIM : rep_cnt;
    assign w_err  = ((mode == 2'd0) && w_over) || !w_b_ok || !w_c_ok || (mode == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= 1'b0;
            r_s1_c     <= 1'b0;
            r_s1_cnt   <= '0;
            r_s1_mode  <= 2'd0;
            r_s1_err   <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a    <= a;
                r_s1_b    <= w_rb;
                r_s1_c    <= w_cb;
                r_s1_cnt  <= w_cnt;
                r_s1_mode <= mode;
                r_s1_err  <= w_err;
            end
        end
    end

    always_comb begin
        w_fill = '0;
        case (r_s1_mode)
            2'd0: begin
                for (int i = 0; i < REP_MAX; i++) begin
                    if (R_W'(i) < r_s1_cnt) w_fill[i] = r_s1_b;
                end
            end
            2'd1:    w_fill = {REP_MAX{r_s1_b}};
            default: w_fill = '0;
        endcase
        w_y = (r_s1_mode == 2'd3) ? '0 : {r_s1_a, w_fill, r_s1_c};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_y        <= '0;
            r_err      <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_y   <= w_y;
                r_err <= r_s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer <= '0;
        end else if (r_s2_valid && out_ready) begin
            r_xfer <= r_xfer + CNT_W'(1);
        end
    end

    assign in_ready  = w_s1_load;
    assign out_valid = r_s2_valid;
    assign y         = r_y;
    assign out_err   = r_err;
    assign xfer_cnt  = r_xfer;

endmodule
